// File: rtl/ifu_gen2.sv
// Instruction fetch unit: one outstanding request, per-slot predecode with a 2-bit BHT, FQ_DEPTH-packet queue.
// Request is combinational from S_REQ, a packet is pushed on the response edge, and a full queue holds off requests.
module ifu_gen2 #(
  parameter int unsigned FETCH_W     = 2,
  parameter int unsigned FQ_DEPTH    = 4,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter logic [31:0] PC_START    = 32'h80000000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_o,
  output logic [31:0]           imem_addr_o,
  input  logic                  imem_rvalid_i,
  input  logic [32*FETCH_W-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  input  logic                  bht_upd_i,
  input  logic [31:0]           bht_upd_pc_i,
  input  logic                  bht_upd_taken_i,
  output logic                  pkt_valid_o,
  input  logic                  pkt_ready_i,
  output logic [31:0]           pkt_pc_o,
  output logic [32*FETCH_W-1:0] pkt_inst_o,
  output logic [FETCH_W-1:0]    pkt_mask_o,
  output logic [FETCH_W-1:0]    pkt_taken_o,
  output logic [31:0]           pkt_target_o
);

  localparam int unsigned IW = 32 * FETCH_W;
  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned BW = $clog2(BHT_ENTRIES);
  localparam logic [PW:0] FULL = (PW + 1)'(FQ_DEPTH);

  typedef struct packed {
    logic [31:0]        pc;
    logic [IW-1:0]      inst;
    logic [FETCH_W-1:0] mask;
    logic [FETCH_W-1:0] taken;
    logic [31:0]        target;
  } pkt_t;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  pkt_t        fq [FQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [1:0]    bht [BHT_ENTRIES];

  pkt_t        dec, head;
  logic [31:0] next_pc, slot_inst, slot_pc, slot_tgt;
  logic [5:0]  op;
  logic        is_br, is_cb, is_jirl, slot_tk, alive;
  logic        req_ok, push, pop;
  logic [BW-1:0] upd_idx;
  logic        unused_upd_bits;

  // Predecode: the first taken or jirl slot closes the packet; later slots stay zero.
  always_comb begin
    dec       = '0;
    dec.pc    = fetch_pc;
    next_pc   = fetch_pc + 32'(4 * FETCH_W);
    alive     = 1'b1;
    slot_inst = '0;
    slot_pc   = '0;
    slot_tgt  = '0;
    op        = '0;
    is_br     = 1'b0;
    is_cb     = 1'b0;
    is_jirl   = 1'b0;
    slot_tk   = 1'b0;
    for (int k = 0; k < FETCH_W; k++) begin
      slot_inst = imem_rdata_i[32*k +: 32];
      slot_pc   = fetch_pc + 32'(4 * k);
      op        = slot_inst[31:26];
      is_br     = (op == 6'b010100) || (op == 6'b010101);
      is_cb     = (op == 6'b010110) || (op == 6'b010111);
      is_jirl   = (op == 6'b010011);
      slot_tk   = is_br || (is_cb && bht[slot_pc[BW+1:2]][1]);
      slot_tgt  = is_br ? slot_pc + {{4{slot_inst[9]}}, slot_inst[9:0], slot_inst[25:10], 2'b00}
                        : slot_pc + {{14{slot_inst[25]}}, slot_inst[25:10], 2'b00};
      if (alive) begin
        dec.mask[k]          = 1'b1;
        dec.taken[k]         = slot_tk;
        dec.inst[32*k +: 32] = slot_inst;
        if (slot_tk) begin
          dec.target = slot_tgt;
          next_pc    = slot_tgt;
        end
        if (slot_tk || is_jirl) alive = 1'b0;
      end
    end
  end

  assign req_ok      = (state == S_REQ) && (count != FULL) && !redirect_i;
  assign imem_req_o  = rst && req_ok;
  assign imem_addr_o = imem_req_o ? fetch_pc : 32'h0;

  assign pkt_valid_o = (count != '0);
  assign push        = (state == S_WAIT) && imem_rvalid_i && !redirect_i;
  assign pop         = pkt_valid_o && pkt_ready_i && !redirect_i;

  assign head         = pkt_valid_o ? fq[rd_ptr] : '0;
  assign pkt_pc_o     = head.pc;
  assign pkt_inst_o   = head.inst;
  assign pkt_mask_o   = head.mask;
  assign pkt_taken_o  = head.taken;
  assign pkt_target_o = head.target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_REQ;
      fetch_pc <= PC_START;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      // An in-flight response arriving with the redirect retires the request immediately.
      if (state == S_REQ) state <= S_REQ;
      else                state <= imem_rvalid_i ? S_REQ : S_DROP;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case (state)
        S_REQ:  if (req_ok) state <= S_WAIT;
        S_WAIT: if (imem_rvalid_i) begin
          state    <= S_REQ;
          fetch_pc <= next_pc;
        end
        S_DROP: if (imem_rvalid_i) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fq[wr_ptr] <= dec;
  end

  assign upd_idx         = bht_upd_pc_i[BW+1:2];
  assign unused_upd_bits = ^{bht_upd_pc_i[31:BW+2], bht_upd_pc_i[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (bht_upd_i) begin
      if (bht_upd_taken_i && bht[upd_idx] != 2'b11)      bht[upd_idx] <= bht[upd_idx] + 2'b01;
      else if (!bht_upd_taken_i && bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
    end
  end

endmodule
